// File: rtl/mips_run_pkg.sv
// Shared types for the MIPS run controller: FSM state encoding and halt-reason codes.
package mips_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_RUN,
    ST_DONE,
    ST_TOUT
  } run_state_t;

  localparam logic [1:0] HC_NONE  = 2'd0;
  localparam logic [1:0] HC_LOOP  = 2'd1;
  localparam logic [1:0] HC_INSTR = 2'd2;
  localparam logic [1:0] HC_TOUT  = 2'd3;

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Control/observation bundle between the run controller and the core side.
interface mips_run_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);

  logic             start;
  logic [PC_W-1:0]  pc;
  logic [31:0]      instr;
  logic             cpu_reset;
  logic             cpu_stall;
  logic             running;
  logic             done;
  logic             timeout;
  logic [1:0]       halt_code;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  start, pc, instr,
    output cpu_reset, cpu_stall, running, done, timeout, halt_code, cycle_count
  );

  modport slave (
    output start, pc, instr,
    input  cpu_reset, cpu_stall, running, done, timeout, halt_code, cycle_count
  );

endinterface

// File: rtl/mips_halt_detect.sv
// Completion detectors: PC self-loop (stable-PC run length) and halt-opcode match.
module mips_halt_detect #(
  parameter int          PC_W          = 32,
  parameter int          HALT_REPEAT   = 4,
  parameter bit          HALT_INSTR_EN = 1'b1,
  parameter logic [31:0] HALT_INSTR    = 32'h0000000C
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clr,
  input  logic            i_run,
  input  logic [PC_W-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic            loop_hit,
  output logic            instr_hit
);

  localparam int SC_W = $clog2(HALT_REPEAT + 1);

  logic [PC_W-1:0] r_prev_pc;
  logic            r_hist_vld;
  logic [SC_W-1:0] r_stable_cnt;
  logic            w_pc_same;

  assign w_pc_same = r_hist_vld && (i_pc == r_prev_pc);

  // Fires on the cycle whose match brings the run length up to HALT_REPEAT.
  assign loop_hit  = i_run && w_pc_same && (r_stable_cnt == SC_W'(HALT_REPEAT - 1));
  assign instr_hit = HALT_INSTR_EN && i_run && (i_instr == HALT_INSTR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_pc    <= '0;
      r_hist_vld   <= 1'b0;
      r_stable_cnt <= '0;
    end else if (i_clr) begin
      r_prev_pc    <= '0;
      r_hist_vld   <= 1'b0;
      r_stable_cnt <= '0;
    end else if (i_run) begin
      r_prev_pc  <= i_pc;
      r_hist_vld <= 1'b1;
      if (w_pc_same) begin
        if (r_stable_cnt != SC_W'(HALT_REPEAT))
          r_stable_cnt <= r_stable_cnt + SC_W'(1);
      end else begin
        r_stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: reset sequencing, cycle
// counting and completion detection (PC loop, halt opcode, cycle budget).
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int          RESET_CYCLES  = 1,
  parameter int          MAX_CYCLES    = 10000,
  parameter int          CNT_W         = 32,
  parameter int          PC_W          = 32,
  parameter int          HALT_REPEAT   = 4,
  parameter bit          HALT_INSTR_EN = 1'b1,
  parameter logic [31:0] HALT_INSTR    = 32'h0000000C
) (
  input  logic           clk,
  input  logic           reset,
  mips_run_ctrl_if.master bus
);

  localparam int RC_W = $clog2(RESET_CYCLES + 1);

  run_state_t       r_state;
  logic [RC_W-1:0]  r_rst_cnt;
  logic [CNT_W-1:0] r_cycle_count;
  logic             r_cpu_reset;
  logic             r_cpu_stall;
  logic             r_running;
  logic             r_done;
  logic             r_timeout;
  logic [1:0]       r_halt_code;
  logic             w_loop_hit;
  logic             w_instr_hit;

  mips_halt_detect #(
    .PC_W          (PC_W),
    .HALT_REPEAT   (HALT_REPEAT),
    .HALT_INSTR_EN (HALT_INSTR_EN),
    .HALT_INSTR    (HALT_INSTR)
  ) u_halt_detect (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (r_state == ST_RST),
    .i_run     (r_state == ST_RUN),
    .i_pc      (bus.pc),
    .i_instr   (bus.instr),
    .loop_hit  (w_loop_hit),
    .instr_hit (w_instr_hit)
  );

  // Outputs are loaded together with the state they belong to, so every
  // output is a registered function of the state just entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_rst_cnt     <= '0;
      r_cycle_count <= '0;
      r_cpu_reset   <= 1'b1;
      r_cpu_stall   <= 1'b0;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_halt_code   <= HC_NONE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_TOUT: begin
          if (bus.start) begin
            r_state       <= ST_RST;
            r_rst_cnt     <= RC_W'(RESET_CYCLES - 1);
            r_cycle_count <= '0;
            r_cpu_reset   <= 1'b1;
            r_cpu_stall   <= 1'b0;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_halt_code   <= HC_NONE;
          end
        end
        ST_RST: begin
          if (r_rst_cnt == '0) begin
            r_state     <= ST_RUN;
            r_cpu_reset <= 1'b0;
            r_running   <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt - RC_W'(1);
          end
        end
        ST_RUN: begin
          r_cycle_count <= r_cycle_count + CNT_W'(1);
          if (w_instr_hit || w_loop_hit) begin
            r_state     <= ST_DONE;
            r_running   <= 1'b0;
            r_cpu_stall <= 1'b1;
            r_done      <= 1'b1;
            r_halt_code <= w_instr_hit ? HC_INSTR : HC_LOOP;
          end else if (r_cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
            r_state     <= ST_TOUT;
            r_running   <= 1'b0;
            r_cpu_stall <= 1'b1;
            r_timeout   <= 1'b1;
            r_halt_code <= HC_TOUT;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cpu_reset <= 1'b1;
          r_cpu_stall <= 1'b0;
          r_running   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_reset   = r_cpu_reset;
  assign bus.cpu_stall   = r_cpu_stall;
  assign bus.running     = r_running;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.halt_code   = r_halt_code;
  assign bus.cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: default instance plus a 5-cycle-reset,
// 30-cycle-budget instance.
module tb_mips_run_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mips_run_ctrl_if #(.PC_W(32), .CNT_W(32)) bus_a ();
  mips_run_ctrl_if #(.PC_W(32), .CNT_W(32)) bus_b ();

  mips_run_ctrl #(
    .RESET_CYCLES(1), .MAX_CYCLES(10000), .CNT_W(32), .PC_W(32),
    .HALT_REPEAT(4), .HALT_INSTR_EN(1'b1), .HALT_INSTR(32'h0000000C)
  ) dut_a (
    .clk(clk), .reset(rst), .bus(bus_a)
  );

  mips_run_ctrl #(
    .RESET_CYCLES(5), .MAX_CYCLES(30), .CNT_W(32), .PC_W(32),
    .HALT_REPEAT(4), .HALT_INSTR_EN(1'b1), .HALT_INSTR(32'h0000000C)
  ) dut_b (
    .clk(clk), .reset(rst), .bus(bus_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
  endtask

  // mode 0: PC +4 forever; mode 1: 0,4,8 then hold; mode 2: +4 up to 60 then hold
  function automatic logic [31:0] pc_of(input int mode, input int n);
    int v;
    if (mode == 1)      v = (n <= 3)  ? 4 * (n - 1) : 8;
    else if (mode == 2) v = (n <= 16) ? 4 * (n - 1) : 60;
    else                v = 4 * (n - 1);
    return 32'(v);
  endfunction

  task automatic run_a(input int mode, input int bound, output int n);
    n = 0;
    while (bus_a.running && n < bound) begin
      n++;
      bus_a.pc    = pc_of(mode, n);
      bus_a.instr = (mode == 2 && n == 20) ? 32'h0000000C : 32'h0;
      tick();
    end
    bus_a.instr = 32'h0;
    chk("a_run_end", bus_a.running, 0);
  endtask

  initial begin
    int n;
    int rlen;
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.pc = '0; bus_a.instr = '0;
    bus_b.start = 1'b0; bus_b.pc = '0; bus_b.instr = '0;
    tick();
    tick();
    chk("rst_cpu_reset", bus_a.cpu_reset, 1);
    chk("rst_stall", bus_a.cpu_stall, 0);
    chk("rst_running", bus_a.running, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_timeout", bus_a.timeout, 0);
    chk("rst_code", bus_a.halt_code, 0);
    chk("rst_count", bus_a.cycle_count, 0);
    rst = 1'b0;
    tick();

    // timeout with ever-advancing PC
    pulse_start_a();
    chk("t1_rst_phase", bus_a.cpu_reset, 1);
    chk("t1_not_run", bus_a.running, 0);
    tick();
    chk("t1_running", bus_a.running, 1);
    chk("t1_cpu_reset_low", bus_a.cpu_reset, 0);
    chk("t1_count0", bus_a.cycle_count, 0);
    run_a(0, 10010, n);
    chk("t1_run_len", 64'(n), 10000);
    chk("t1_timeout", bus_a.timeout, 1);
    chk("t1_code", bus_a.halt_code, 3);
    chk("t1_count", bus_a.cycle_count, 10000);
    chk("t1_done", bus_a.done, 0);
    chk("t1_stall", bus_a.cpu_stall, 1);
    chk("t1_cpu_reset", bus_a.cpu_reset, 0);
    tick();
    tick();
    chk("t1_frozen", bus_a.cycle_count, 10000);
    chk("t1_sticky", bus_a.timeout, 1);

    // restart from TOUT, PC loop halt
    pulse_start_a();
    chk("t2_clr_timeout", bus_a.timeout, 0);
    chk("t2_clr_code", bus_a.halt_code, 0);
    chk("t2_clr_count", bus_a.cycle_count, 0);
    chk("t2_cpu_reset", bus_a.cpu_reset, 1);
    chk("t2_stall", bus_a.cpu_stall, 0);
    tick();
    chk("t2_running", bus_a.running, 1);
    run_a(1, 100, n);
    chk("t2_run_len", 64'(n), 7);
    chk("t2_done", bus_a.done, 1);
    chk("t2_code", bus_a.halt_code, 1);
    chk("t2_count", bus_a.cycle_count, 7);

    // restart from DONE, halt opcode beats simultaneous PC loop
    pulse_start_a();
    chk("t3_clr_done", bus_a.done, 0);
    chk("t3_clr_code", bus_a.halt_code, 0);
    tick();
    run_a(2, 100, n);
    chk("t3_code", bus_a.halt_code, 2);
    chk("t3_count", bus_a.cycle_count, 20);
    chk("t3_done", bus_a.done, 1);
    chk("t3_timeout", bus_a.timeout, 0);

    // asynchronous reset in the middle of RUN
    pulse_start_a();
    tick();
    for (int i = 1; i <= 5; i++) begin
      bus_a.pc = pc_of(0, i);
      tick();
    end
    chk("t4_count_mid", bus_a.cycle_count, 5);
    #3 rst = 1'b1;
    #1;
    chk("t4_cpu_reset", bus_a.cpu_reset, 1);
    chk("t4_running", bus_a.running, 0);
    chk("t4_count", bus_a.cycle_count, 0);
    chk("t4_done", bus_a.done, 0);
    chk("t4_timeout", bus_a.timeout, 0);
    chk("t4_code", bus_a.halt_code, 0);
    #1 rst = 1'b0;
    tick();
    pulse_start_a();
    chk("t4_restart_count", bus_a.cycle_count, 0);
    tick();
    run_a(1, 100, n);
    chk("t4_code2", bus_a.halt_code, 1);
    chk("t4_count2", bus_a.cycle_count, 7);

    // five-cycle reset, start ignored during RUN, small budget timeout
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    rlen = 0;
    while (bus_b.cpu_reset && rlen < 20) begin
      rlen++;
      tick();
    end
    chk("t5_reset_len", 64'(rlen), 5);
    chk("t5_running", bus_b.running, 1);
    for (int i = 1; i <= 3; i++) begin
      bus_b.pc = pc_of(0, i);
      tick();
    end
    chk("t5_count3", bus_b.cycle_count, 3);
    bus_b.start = 1'b1;
    bus_b.pc = pc_of(0, 4);
    tick();
    bus_b.start = 1'b0;
    chk("t5_start_ign_run", bus_b.running, 1);
    chk("t5_start_ign_cnt", bus_b.cycle_count, 4);
    chk("t5_start_ign_rst", bus_b.cpu_reset, 0);
    n = 4;
    while (bus_b.running && n < 100) begin
      n++;
      bus_b.pc = pc_of(0, n);
      tick();
    end
    chk("t5_count", bus_b.cycle_count, 30);
    chk("t5_timeout", bus_b.timeout, 1);
    chk("t5_code", bus_b.halt_code, 3);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
